// File: rtl/miriscv_fetch_aligner.sv
// Realigns word-aligned fetch words into 16/32-bit instructions with their PCs; result visible
// the cycle after the word is accepted; fetch is stalled while more than two halfwords are held.
package miriscv_pkg;
    localparam int ILEN = 32;
    localparam int XLEN = 32;
endpackage

module miriscv_fetch_aligner #(
    parameter int              ILEN     = miriscv_pkg::ILEN,
    parameter int              XLEN     = miriscv_pkg::XLEN,
    parameter bit              RV32C    = 1'b1,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            word_valid_i,
    output logic            word_ready_o,
    input  logic [ILEN-1:0] word_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_compressed_o
);

    logic [15:0]     buf_q [4];
    logic [15:0]     buf_s [4];
    logic [15:0]     buf_d [4];
    logic [2:0]      cnt_q, cnt_s, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            skip_q, skip_d;
    logic            is32, pop, push;
    logic [2:0]      need;

    assign is32 = !RV32C || (buf_q[0][1:0] == 2'b11);
    assign need = is32 ? 3'd2 : 3'd1;

    assign instr_valid_o      = !flush_i && (cnt_q >= need);
    assign word_ready_o       = !flush_i && (cnt_q <= 3'd2);
    assign instr_o            = is32 ? {buf_q[1], buf_q[0]} : {16'h0000, buf_q[0]};
    assign instr_pc_o         = pc_q;
    // An empty buffer has no head, so it is not reported as compressed.
    assign instr_compressed_o = !is32 && (cnt_q != 3'd0);

    assign pop  = instr_valid_o && instr_ready_i;
    assign push = word_valid_i && word_ready_o;

    always_comb begin
        buf_s = buf_q;
        cnt_s = cnt_q;
        if (pop) begin
            cnt_s = cnt_q - need;
            if (is32) begin
                buf_s[0] = buf_q[2];
                buf_s[1] = buf_q[3];
                buf_s[2] = '0;
                buf_s[3] = '0;
            end else begin
                buf_s[0] = buf_q[1];
                buf_s[1] = buf_q[2];
                buf_s[2] = buf_q[3];
                buf_s[3] = '0;
            end
        end

        buf_d  = buf_s;
        cnt_d  = cnt_s;
        skip_d = skip_q;
        pc_d   = pop ? pc_q + XLEN'({need, 1'b0}) : pc_q;

        // Appending after the pop keeps the head contiguous; cnt_s <= 2 whenever push is set.
        if (push) begin
            if (skip_q) begin
                for (int i = 0; i < 4; i++)
                    if (3'(i) == cnt_s) buf_d[i] = word_i[31:16];
                cnt_d  = cnt_s + 3'd1;
                skip_d = 1'b0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (3'(i) == cnt_s)        buf_d[i] = word_i[15:0];
                    if (3'(i) == cnt_s + 3'd1) buf_d[i] = word_i[31:16];
                end
                cnt_d = cnt_s + 3'd2;
            end
        end

        if (flush_i) begin
            cnt_d  = 3'd0;
            pc_d   = flush_pc_i;
            skip_d = flush_pc_i[1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= 3'd0;
            pc_q   <= RESET_PC;
            skip_q <= RESET_PC[1];
            for (int i = 0; i < 4; i++) buf_q[i] <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pc_q   <= pc_d;
            skip_q <= skip_d;
            buf_q  <= buf_d;
        end
    end

endmodule

// File: tb/tb_miriscv_fetch_aligner.sv
// Bench for the fetch aligner: queue-of-halfwords model checked every cycle plus directed literals.
module tb_miriscv_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        word_valid = 1'b0, word_ready;
    logic [31:0] word = '0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        instr_valid, instr_ready = 1'b0, instr_c;
    logic [31:0] instr, instr_pc;

    logic        w0_valid = 1'b0, w0_ready;
    logic [31:0] w0 = '0;
    logic        f0 = 1'b0;
    logic [31:0] f0_pc = '0;
    logic        i0_valid, i0_ready = 1'b0, i0_c;
    logic [31:0] i0, i0_pc;

    always #5 clk = ~clk;

    miriscv_fetch_aligner #(.RV32C(1'b1), .RESET_PC(32'h0)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .word_valid_i(word_valid), .word_ready_o(word_ready), .word_i(word),
        .flush_i(flush), .flush_pc_i(flush_pc),
        .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
        .instr_o(instr), .instr_pc_o(instr_pc), .instr_compressed_o(instr_c)
    );

    miriscv_fetch_aligner #(.RV32C(1'b0), .RESET_PC(32'h10)) u_dut_nc (
        .clk_i(clk), .rst_i(rst),
        .word_valid_i(w0_valid), .word_ready_o(w0_ready), .word_i(w0),
        .flush_i(f0), .flush_pc_i(f0_pc),
        .instr_valid_o(i0_valid), .instr_ready_i(i0_ready),
        .instr_o(i0), .instr_pc_o(i0_pc), .instr_compressed_o(i0_c)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Model: the program as a queue of halfwords starting at mpc.
    logic [15:0] mq[$];
    logic [31:0] mpc = 32'h0;
    logic        mskip = 1'b0;

    function automatic logic m_is32();
        return (mq.size() > 0) && (mq[0][1:0] == 2'b11);
    endfunction
    function automatic logic m_valid();
        return !flush && (mq.size() >= (m_is32() ? 2 : 1));
    endfunction
    function automatic logic m_ready();
        return !flush && (mq.size() <= 2);
    endfunction
    function automatic logic [31:0] m_instr();
        return m_is32() ? {mq[1], mq[0]} : {16'h0000, mq[0]};
    endfunction

    typedef struct packed {
        logic [31:0] i;
        logic [31:0] pc;
        logic        c;
    } ent_t;
    ent_t log_q[$];

    initial begin
        int n;
        logic pv, pu;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                mpc   = 32'h0;
                mskip = 1'b0;
            end else if (flush) begin
                mq.delete();
                mpc   = flush_pc;
                mskip = flush_pc[1];
            end else begin
                pv = m_valid() && instr_ready;
                pu = m_ready() && word_valid;
                if (pv) begin
                    n = m_is32() ? 2 : 1;
                    repeat (n) void'(mq.pop_front());
                    mpc = mpc + 32'(2 * n);
                end
                if (pu) begin
                    if (mskip) begin
                        mq.push_back(word[31:16]);
                        mskip = 1'b0;
                    end else begin
                        mq.push_back(word[15:0]);
                        mq.push_back(word[31:16]);
                    end
                end
            end
        end
    end

    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("valid", 32'(instr_valid), 32'(m_valid()));
                check("word_ready", 32'(word_ready), 32'(m_ready()));
                if (m_valid()) begin
                    check("instr", instr, m_instr());
                    check("pc", instr_pc, mpc);
                    check("compressed", 32'(instr_c), 32'(!m_is32()));
                end
                if (instr_valid && instr_ready) begin
                    e.i  = instr;
                    e.pc = instr_pc;
                    e.c  = instr_c;
                    log_q.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic push_word(input logic [31:0] w);
        logic ok;
        ok = 1'b0;
        word_valid = 1'b1;
        word = w;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            ok = word_ready;
            @(posedge clk);
            #1;
        end
        word_valid = 1'b0;
        if (!ok) check("push_accept", 32'(ok), 32'h1);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        flush = 1'b0;
        word_valid = 1'b0;
        instr_ready = 1'b0;
        step();
        rst = 1'b0;
        log_q.delete();
    endtask

    task automatic log_chk(input string name, input int idx, input logic [31:0] i,
                           input logic [31:0] pc, input logic c);
        if (idx < log_q.size()) begin
            check({name, "_instr"}, log_q[idx].i, i);
            check({name, "_pc"}, log_q[idx].pc, pc);
            check({name, "_c"}, 32'(log_q[idx].c), 32'(c));
        end else begin
            check({name, "_present"}, 32'(log_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle(2);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_c", 32'(instr_c), 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_pc_nc", i0_pc, 32'h10);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(word_ready), 32'h1);

        // Aligned 32-bit pair
        instr_ready = 1'b1;
        log_q.delete();
        push_word(32'h00500093);
        check("t1_latency", 32'(instr_valid), 32'h1);
        push_word(32'h00A00113);
        idle(4);
        log_chk("t1_0", 0, 32'h00500093, 32'h0, 1'b0);
        log_chk("t1_1", 1, 32'h00A00113, 32'h4, 1'b0);
        check("t1_count", 32'(log_q.size()), 32'd2);

        // Compressed pair
        do_reset();
        instr_ready = 1'b1;
        push_word(32'h45050001);
        idle(4);
        log_chk("t2_0", 0, 32'h00000001, 32'h0, 1'b1);
        log_chk("t2_1", 1, 32'h00004505, 32'h2, 1'b1);

        // Straddling 32-bit instruction
        do_reset();
        instr_ready = 1'b1;
        push_word(32'h00934505);
        push_word(32'h00010050);
        idle(4);
        log_chk("t3_0", 0, 32'h00004505, 32'h0, 1'b1);
        log_chk("t3_1", 1, 32'h00500093, 32'h2, 1'b0);
        log_chk("t3_2", 2, 32'h00000001, 32'h6, 1'b1);
        check("t3_count", 32'(log_q.size()), 32'd3);

        // Back-to-back flush to a halfword PC with a full buffer
        do_reset();
        push_word(32'h00500093);
        push_word(32'h00A00113);
        flush = 1'b1;
        flush_pc = 32'h200;
        word_valid = 1'b1;
        word = 32'hDEADBEEF;
        #3;
        check("fl_valid", 32'(instr_valid), 32'h0);
        check("fl_ready", 32'(word_ready), 32'h0);
        step();
        flush_pc = 32'h102;
        step();
        flush = 1'b0;
        word_valid = 1'b0;
        instr_ready = 1'b1;
        log_q.delete();
        push_word(32'h00010093);
        idle(4);
        log_chk("t4_0", 0, 32'h00000001, 32'h102, 1'b1);
        check("t4_count", 32'(log_q.size()), 32'd1);

        // Backpressure with compressed stream
        do_reset();
        push_word(32'h45050001);
        push_word(32'h40814501);
        check("bp_ready", 32'(word_ready), 32'h0);
        fork
            push_word(32'h00210011);
            begin
                idle(3);
                instr_ready = 1'b1;
            end
        join
        idle(8);
        log_chk("t5_0", 0, 32'h00000001, 32'h0, 1'b1);
        log_chk("t5_1", 1, 32'h00004505, 32'h2, 1'b1);
        log_chk("t5_2", 2, 32'h00004501, 32'h4, 1'b1);
        log_chk("t5_3", 3, 32'h00004081, 32'h6, 1'b1);
        log_chk("t5_4", 4, 32'h00000011, 32'h8, 1'b1);
        log_chk("t5_5", 5, 32'h00000021, 32'hA, 1'b1);
        check("t5_count", 32'(log_q.size()), 32'd6);

        // Asynchronous reset with three halfwords buffered
        do_reset();
        push_word(32'h45050001);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        push_word(32'h00934505);
        check("mr_pre_valid", 32'(instr_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("mr_valid", 32'(instr_valid), 32'h0);
        check("mr_instr", instr, 32'h0);
        check("mr_c", 32'(instr_c), 32'h0);
        check("mr_pc", instr_pc, 32'h0);
        idle(2);
        rst = 1'b0;
        #1;
        check("mr_ready", 32'(word_ready), 32'h1);

        // No compressed support
        w0_valid = 1'b1;
        w0 = 32'h45050001;
        step();
        w0_valid = 1'b0;
        check("nc_valid", 32'(i0_valid), 32'h1);
        check("nc_instr", i0, 32'h45050001);
        check("nc_c", 32'(i0_c), 32'h0);
        check("nc_pc", i0_pc, 32'h10);
        i0_ready = 1'b1;
        step();
        i0_ready = 1'b0;
        check("nc_empty", 32'(i0_valid), 32'h0);
        f0 = 1'b1;
        f0_pc = 32'h102;
        step();
        f0 = 1'b0;
        w0_valid = 1'b1;
        w0 = 32'h00010093;
        step();
        w0 = 32'h00001234;
        check("nc_wait", 32'(i0_valid), 32'h0);
        step();
        w0_valid = 1'b0;
        check("nc_str_valid", 32'(i0_valid), 32'h1);
        check("nc_str_instr", i0, 32'h12340001);
        check("nc_str_pc", i0_pc, 32'h102);
        check("nc_str_c", 32'(i0_c), 32'h0);

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
